// File: rtl/jtframe_scroll_tilemap_if.sv
// Memory-side bus of the scroll tilemap renderer:
// VRAM map fetch, graphics ROM fetch and line-buffer writes.
interface jtframe_scroll_tilemap_if #(
  parameter int AW  = 12,
  parameter int RAW = 20,
  parameter int PW  = 5
);
  logic [AW-1:0]  vram_addr;
  logic           vram_cs;
  logic [31:0]    vram_data;
  logic           vram_ok;
  logic [RAW-1:0] rom_addr;
  logic           rom_cs;
  logic [31:0]    rom_data;
  logic           rom_ok;
  logic [8:0]     buf_addr;
  logic [PW+3:0]  buf_data;
  logic           buf_wr;

  modport master (
    output vram_addr, vram_cs,
    input  vram_data, vram_ok,
    output rom_addr, rom_cs,
    input  rom_data, rom_ok,
    output buf_addr, buf_data, buf_wr
  );

  modport slave (
    input  vram_addr, vram_cs,
    output vram_data, vram_ok,
    input  rom_addr, rom_cs,
    output rom_data, rom_ok,
    input  buf_addr, buf_data, buf_wr
  );
endinterface

// File: rtl/jtframe_scroll_tilemap.sv
// Scrolling tile layer line renderer: map fetch, 4bpp planar
// ROM fetch, flips, wrap-around and line-buffer writes.
module jtframe_scroll_tilemap #(
  parameter int TW     = 8,
  parameter int PW     = 5,
  parameter int MAP_W  = 6,
  parameter int MAP_H  = 6,
  parameter int LINE_W = 256,
  parameter int RAW    = 20
)(
  input  logic       rst,
  input  logic       clk,
  input  logic [8:0] vrender,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       start,
  input  logic       stop,
  output logic       done,
  jtframe_scroll_tilemap_if.master bus
);
  localparam int TB  = (TW == 16) ? 4 : 3;
  localparam int HB  = (TW == 16) ? 1 : 0;
  localparam bit T16 = (TW == 16);

  typedef enum logic [2:0] {
    IDLE, MAP, WAITV, ROM, WAITR, DRAW, DONE
  } state_t;

  state_t state, nxt;

  logic [9:0]    vn, hn, cnt;
  logic [15:0]   code, attr;
  logic [31:0]   pix, psh, vsh, hsh, rfull;
  logic [2:0]    k, sel, skip;
  logic [TB-1:0] row;
  logic [3:0]    colour;
  logic          half, hflip, vflip;
  logic          wr_now, last_px, tile_end;
  logic          unused_bits;

  assign hflip    = attr[14];
  assign vflip    = attr[15];
  assign sel      = hflip ? ~k : k;
  // pixel k sits at bit 31-k of each plane byte
  assign psh      = pix << sel;
  assign colour   = {psh[31], psh[23], psh[15], psh[7]};
  assign wr_now   = skip == 3'd0;
  assign last_px  = wr_now && cnt == 10'(LINE_W - 1);
  assign tile_end = k == 3'd7;
  assign vsh      = 32'(vn) >> TB;
  assign hsh      = 32'(hn) >> TB;
  assign row      = vn[TB-1:0] ^ {TB{vflip}};
  assign half     = T16 ? hn[3] ^ hflip : 1'b0;
  assign rfull    = (32'(code) << (TB + HB))
                  | (32'(half) << TB)
                  | 32'(row);
  assign unused_bits = ^{vn, hn, attr, psh, vsh, hsh, rfull};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start && !stop) nxt = MAP;
      MAP:   nxt = WAITV;
      WAITV: if (bus.vram_ok) nxt = ROM;
      ROM:   nxt = WAITR;
      WAITR: if (bus.rom_ok) nxt = DRAW;
      DRAW: begin
        if (last_px) nxt = DONE;
        else if (tile_end)
          nxt = (T16 && !hn[3]) ? ROM : MAP;
      end
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (stop && state != IDLE && state != DONE)
      nxt = DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done          <= 1'b0;
      vn            <= '0;
      hn            <= '0;
      cnt           <= '0;
      code          <= '0;
      attr          <= '0;
      pix           <= '0;
      k             <= '0;
      skip          <= '0;
      bus.vram_addr <= '0;
      bus.vram_cs   <= 1'b0;
      bus.rom_addr  <= '0;
      bus.rom_cs    <= 1'b0;
      bus.buf_addr  <= '0;
      bus.buf_data  <= '0;
      bus.buf_wr    <= 1'b0;
    end else if (stop && state != IDLE) begin
      bus.buf_wr  <= 1'b0;
      bus.vram_cs <= 1'b0;
      bus.rom_cs  <= 1'b0;
      done        <= 1'b1;
    end else begin
      bus.buf_wr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (stop) done <= 1'b1;
          else if (start) begin
            vn   <= 10'(vrender) + vpos;
            hn   <= hpos;
            cnt  <= '0;
            skip <= hpos[2:0];
            done <= 1'b0;
          end
        end
        MAP: begin
          bus.vram_addr <= {vsh[MAP_H-1:0], hsh[MAP_W-1:0]};
          bus.vram_cs   <= 1'b1;
        end
        WAITV: begin
          if (bus.vram_ok) begin
            code        <= bus.vram_data[15:0];
            attr        <= bus.vram_data[31:16];
            bus.vram_cs <= 1'b0;
          end
        end
        ROM: begin
          bus.rom_addr <= rfull[RAW-1:0];
          bus.rom_cs   <= 1'b1;
        end
        WAITR: begin
          if (bus.rom_ok) begin
            pix        <= bus.rom_data;
            bus.rom_cs <= 1'b0;
            k          <= '0;
          end
        end
        DRAW: begin
          k <= k + 3'd1;
          if (wr_now) begin
            bus.buf_wr   <= 1'b1;
            bus.buf_addr <= cnt[8:0];
            bus.buf_data <= {attr[PW-1:0], colour};
            cnt          <= cnt + 10'd1;
          end else begin
            skip <= skip - 3'd1;
          end
          if (tile_end) hn <= hn + 10'd8;
        end
        DONE: begin
          bus.vram_cs <= 1'b0;
          bus.rom_cs  <= 1'b0;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_jtframe_scroll_tilemap.sv
// Bench for jtframe_scroll_tilemap: 8x8 and 16x16 instances
// checked against a pixel-level model of the tile layer.
module tb_jtframe_scroll_tilemap;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [8:0] vrender;
  logic [9:0] hpos, vpos;
  logic start8, start16, stop, done8, done16;
  logic vok, rok, ok_rand;
  logic rom_cmode;
  logic [31:0] rom_const, rom_key;
  logic [31:0] vmem [0:4095];

  int checks = 0;
  int failures = 0;

  jtframe_scroll_tilemap_if #(.AW(12), .RAW(20), .PW(5)) b8 ();
  jtframe_scroll_tilemap_if #(.AW(12), .RAW(20), .PW(5)) b16 ();

  jtframe_scroll_tilemap #(.TW(8)) u8 (
    .rst(rst), .clk(clk), .vrender(vrender),
    .hpos(hpos), .vpos(vpos), .start(start8),
    .stop(stop), .done(done8), .bus(b8)
  );

  jtframe_scroll_tilemap #(.TW(16)) u16 (
    .rst(rst), .clk(clk), .vrender(vrender),
    .hpos(hpos), .vpos(vpos), .start(start16),
    .stop(stop), .done(done16), .bus(b16)
  );

  function automatic logic [31:0] rom_word(
    logic [19:0] a, logic m, logic [31:0] c, logic [31:0] key);
    if (m) return c;
    return ({12'd0, a} * 32'h9E3779B1) ^ key;
  endfunction

  assign b8.vram_data  = vmem[b8.vram_addr];
  assign b8.vram_ok    = vok;
  assign b8.rom_data   = rom_word(b8.rom_addr, rom_cmode, rom_const, rom_key);
  assign b8.rom_ok     = rok;
  assign b16.vram_data = vmem[b16.vram_addr];
  assign b16.vram_ok   = vok;
  assign b16.rom_data  = rom_word(b16.rom_addr, rom_cmode, rom_const, rom_key);
  assign b16.rom_ok    = rok;

  logic act16;
  logic c_wr, c_vcs, c_rcs, c_done;
  logic [8:0] c_addr, c_data;
  logic [11:0] c_vaddr;
  logic [19:0] c_raddr;
  assign c_wr    = act16 ? b16.buf_wr   : b8.buf_wr;
  assign c_addr  = act16 ? b16.buf_addr : b8.buf_addr;
  assign c_data  = act16 ? b16.buf_data : b8.buf_data;
  assign c_vcs   = act16 ? b16.vram_cs  : b8.vram_cs;
  assign c_rcs   = act16 ? b16.rom_cs   : b8.rom_cs;
  assign c_vaddr = act16 ? b16.vram_addr : b8.vram_addr;
  assign c_raddr = act16 ? b16.rom_addr : b8.rom_addr;
  assign c_done  = act16 ? done16 : done8;

  logic [8:0] got [0:511];
  logic [11:0] vaq [$];
  logic [19:0] raq [$];
  int wcount, cyc, start_cyc, first_wr_cyc;
  bit seq_err, pv, pr;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // all sampling happens on the falling edge, away from the active edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (c_wr) begin
      if (c_addr != 9'(wcount)) seq_err = 1'b1;
      if (wcount == 0) first_wr_cyc = cyc;
      got[c_addr] = c_data;
      wcount++;
    end
    if (c_vcs && !pv) vaq.push_back(c_vaddr);
    if (c_rcs && !pr) raq.push_back(c_raddr);
    pv = c_vcs;
    pr = c_rcs;
    if (ok_rand) begin
      vok = 1'($urandom_range(0, 1));
      rok = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic clear_cap();
    for (int i = 0; i < 512; i++) got[i] = 'x;
    vaq.delete();
    raq.delete();
    wcount = 0;
    seq_err = 1'b0;
    first_wr_cyc = -1;
  endtask

  function automatic logic [8:0] exp_px(
    bit is16, logic [8:0] vr, logic [9:0] hp, logic [9:0] vp, int i);
    int tw, x, y, px, ry, k, a;
    logic [31:0] e, w;
    tw = is16 ? 16 : 8;
    x = (int'(hp) + i) % 1024;
    y = (int'(vr) + int'(vp)) % 1024;
    e = vmem[((y / tw) % 64) * 64 + (x / tw) % 64];
    px = x % tw;
    ry = y % tw;
    if (e[30]) px = tw - 1 - px;
    if (e[31]) ry = tw - 1 - ry;
    if (is16) a = int'(e[15:0]) * 32 + (px / 8) * 16 + ry;
    else      a = int'(e[15:0]) * 8 + ry;
    w = rom_word(20'(a), rom_cmode, rom_const, rom_key);
    k = px % 8;
    return {e[20:16], w[31-k], w[23-k], w[15-k], w[7-k]};
  endfunction

  task automatic start_line(
    bit is16, logic [8:0] vr, logic [9:0] hp, logic [9:0] vp);
    act16 = is16;
    clear_cap();
    vrender = vr;
    hpos = hp;
    vpos = vp;
    if (is16) start16 = 1'b1;
    else      start8 = 1'b1;
    start_cyc = cyc;
    tick();
    start8 = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic wait_line(string tag);
    int n;
    for (n = 0; n < 20000 && !c_done; n++) tick();
    chk({tag, "_done"}, 32'(c_done), 32'd1);
    chk({tag, "_nowr"}, 32'(c_wr), 32'd0);
  endtask

  task automatic wait_wr(int target, string tag);
    for (int n = 0; n < 5000 && wcount < target; n++) tick();
    chk(tag, 32'(wcount), 32'(target));
  endtask

  task automatic compare_line(
    bit is16, logic [8:0] vr, logic [9:0] hp, logic [9:0] vp, string tag);
    int nbad, first;
    logic [8:0] e, g0, e0;
    nbad = 0;
    first = -1;
    g0 = '0;
    e0 = '0;
    for (int i = 0; i < 256; i++) begin
      e = exp_px(is16, vr, hp, vp, i);
      if (got[i] !== e) begin
        if (first < 0) begin
          first = i;
          g0 = got[i];
          e0 = e;
        end
        nbad++;
      end
    end
    checks++;
    assert (nbad == 0) else begin
      failures++;
      $error("FAIL %s_px bad=%0d first=%0d got=%h exp=%h",
             tag, nbad, first, g0, e0);
    end
    chk({tag, "_cnt"}, 32'(wcount), 32'd256);
    chk({tag, "_seq"}, 32'(seq_err), 32'd0);
  endtask

  task automatic run_line(
    bit is16, logic [8:0] vr, logic [9:0] hp, logic [9:0] vp, string tag);
    start_line(is16, vr, hp, vp);
    wait_line(tag);
    compare_line(is16, vr, hp, vp, tag);
  endtask

  initial begin
    logic [31:0] w;
    logic [19:0] ra;
    bit held;
    bit r16;
    vrender = '0; hpos = '0; vpos = '0;
    start8 = 1'b0; start16 = 1'b0; stop = 1'b0;
    vok = 1'b1; rok = 1'b1; ok_rand = 1'b0;
    rom_cmode = 1'b1; rom_const = 32'hFFFF_FFFF; rom_key = '0;
    act16 = 1'b0; cyc = 0; pv = 1'b0; pr = 1'b0;
    clear_cap();
    for (int i = 0; i < 4096; i++) vmem[i] = 32'(i);

    tick(); tick();
    chk("rst_done8", 32'(done8), 0);
    chk("rst_done16", 32'(done16), 0);
    chk("rst_buf_wr", 32'(b8.buf_wr), 0);
    chk("rst_vcs", 32'(b8.vram_cs), 0);
    chk("rst_rcs", 32'(b16.rom_cs), 0);
    chk("rst_baddr", 32'(b8.buf_addr), 0);
    chk("rst_bdata", 32'(b16.buf_data), 0);
    chk("rst_raddr", 32'(b16.rom_addr), 0);
    rst = 1'b0;
    tick();

    // stop while idle only raises done
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("idle_stop_done", 32'(done8), 1);
    tick(); tick(); tick();
    chk("idle_stop_nofetch", 32'(vaq.size()), 0);

    // flat line, all colour F
    run_line(0, 9'd0, 10'd0, 10'd0, "t1");
    chk("t1_px0", 32'(got[0]), 32'h00F);
    chk("t1_px255", 32'(got[255]), 32'h00F);
    chk("t1_latency", 32'(first_wr_cyc - start_cyc >= 4), 1);
    chk("t1_vfirst", 32'(vaq.size() > 0 ? vaq[0] : 12'hFFF), 0);
    chk("t1_tiles", 32'(vaq.size()), 32);

    // fine horizontal scroll
    rom_cmode = 1'b0;
    rom_key = $urandom;
    run_line(0, 9'd0, 10'd3, 10'd0, "t2");
    w = rom_word(20'd0, 1'b0, rom_const, rom_key);
    chk("t2_px0", 32'(got[0]), 32'({5'd0, w[28], w[20], w[12], w[4]}));
    w = rom_word(20'(32 * 8), 1'b0, rom_const, rom_key);
    chk("t2_px255", 32'(got[255]), 32'({5'd0, w[29], w[21], w[13], w[5]}));

    // both flips
    for (int i = 0; i < 4096; i++) vmem[i] = {16'hC000, 16'(i)};
    rom_cmode = 1'b1;
    rom_const = 32'h0000_0001;
    run_line(0, 9'd0, 10'd0, 10'd0, "t3");
    chk("t3_px0", 32'(got[0]), 1);
    chk("t3_px1", 32'(got[1]), 0);
    chk("t3_px7", 32'(got[7]), 0);
    chk("t3_vflip_row0", 32'(raq.size() > 0 ? raq[0] : 20'hFFFFF), 7);
    chk("t3_vflip_row1", 32'(raq.size() > 1 ? raq[1] : 20'hFFFFF), 15);

    // 16x16 tiles, vertical wrap and map wrap
    for (int i = 0; i < 4096; i++)
      vmem[i] = {$urandom} & 32'h3FFF_FFFF;
    rom_cmode = 1'b0;
    rom_key = $urandom;
    run_line(1, 9'd16, 10'h3F0, 10'h3F8, "t4");
    chk("t4_col63", 32'(vaq.size() > 0 ? vaq[0] : 12'hFFF), 63);
    chk("t4_col0", 32'(vaq.size() > 2 ? vaq[1] : 12'hFFF), 0);
    ra = 20'(int'(vmem[63][15:0]) * 32 + 8);
    chk("t4_rom_row8", 32'(raq.size() > 0 ? raq[0] : 20'hFFFFF), 32'(ra));

    // VRAM stall
    vok = 1'b0;
    start_line(0, 9'd9, 10'd21, 10'd4);
    tick();
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!b8.vram_cs) held = 1'b0;
    end
    chk("t5_vcs_held", 32'(held), 1);
    chk("t5_no_wr", 32'(wcount), 0);
    vok = 1'b1;
    wait_line("t5");
    compare_line(0, 9'd9, 10'd21, 10'd4, "t5");

    // abort mid-tile
    start_line(0, 9'd5, 10'd0, 10'd7);
    wait_wr(12, "t5_reach12");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_wr", 32'(b8.buf_wr), 0);
    chk("stop_done", 32'(done8), 1);
    chk("stop_vcs", 32'(b8.vram_cs), 0);
    chk("stop_rcs", 32'(b8.rom_cs), 0);
    tick(); tick(); tick();
    chk("stop_nomore", 32'(wcount), 12);

    // start while busy is ignored
    start_line(1, 9'd100, 10'd77, 10'd300);
    wait_wr(40, "t6_reach40");
    start16 = 1'b1;
    tick(); tick();
    start16 = 1'b0;
    wait_line("t6");
    compare_line(1, 9'd100, 10'd77, 10'd300, "t6");

    // asynchronous reset while waiting on ROM
    rok = 1'b0;
    start_line(0, 9'd0, 10'd0, 10'd0);
    for (int n = 0; n < 50 && !b8.rom_cs; n++) tick();
    chk("t6_rcs_up", 32'(b8.rom_cs), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_rcs", 32'(b8.rom_cs), 0);
    chk("arst_wr", 32'(b8.buf_wr), 0);
    chk("arst_done", 32'(done8), 0);
    tick();
    rst = 1'b0;
    rok = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("arst_idle_vq", 32'(vaq.size()), 1);
    chk("arst_idle_wr", 32'(wcount), 0);
    chk("arst_idle_done", 32'(done8), 0);

    // randomized lines with random ok latency
    ok_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4096; i++) vmem[i] = $urandom;
      rom_key = $urandom;
      r16 = 1'($urandom_range(0, 1));
      run_line(r16, 9'($urandom), 10'($urandom), 10'($urandom), "rnd");
    end
    ok_rand = 1'b0;
    vok = 1'b1;
    rok = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
